// File: rtl/issue_exe_stage_pkg.sv
// Shared types and width helpers for the N-lane issue->EXE stage.
package issue_exe_stage_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  // Width needed to hold a cut index in 0..lanes (lanes means "no cut").
  function automatic int cut_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/issue_exe_stage_steer.sv
// Combinational lane steering: finds the second-special cut and maps the
// issued slots onto lanes, with the special slot forced to SPECIAL_LANE.
module issue_lane_steer
  import issue_exe_stage_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int SPECIAL_LANE = LANES - 1,
  parameter int SEQ_W        = $clog2(LANES),
  parameter int CUT_W        = cut_width(LANES)
) (
  input  logic [LANES-1:0]       valid,
  input  logic [LANES-1:0]       special,
  output logic [CUT_W-1:0]       cut,
  output logic [LANES-1:0]       lane_valid,
  output logic [LANES*SEQ_W-1:0] lane_src,
  output logic [LANES*SEQ_W-1:0] lane_seq
);

  always_comb begin
    int   nspec;
    int   p;
    int   s;
    logic has_spec;
    nspec      = 0;
    p          = 0;
    s          = 0;
    has_spec   = 1'b0;
    cut        = CUT_W'(LANES);
    lane_valid = '0;
    lane_src   = '0;
    lane_seq   = '0;

    for (int i = 0; i < LANES; i++) begin
      if (valid[i] && special[i]) begin
        nspec++;
        if (nspec == 2) cut = CUT_W'(i);
      end
    end

    for (int i = 0; i < LANES; i++) begin
      if (valid[i] && special[i] && (i < int'(cut))) has_spec = 1'b1;
    end

    // Non-special slots only skip the special lane when it is actually taken.
    for (int i = 0; i < LANES; i++) begin
      if (valid[i] && (i < int'(cut))) begin
        if (special[i]) begin
          lane_valid[SPECIAL_LANE]                 = 1'b1;
          lane_src[SPECIAL_LANE*SEQ_W +: SEQ_W]    = SEQ_W'(i);
          lane_seq[SPECIAL_LANE*SEQ_W +: SEQ_W]    = SEQ_W'(s);
        end else begin
          if (has_spec && (p == SPECIAL_LANE)) p++;
          if (p < LANES) begin
            lane_valid[p]              = 1'b1;
            lane_src[p*SEQ_W +: SEQ_W] = SEQ_W'(i);
            lane_seq[p*SEQ_W +: SEQ_W] = SEQ_W'(s);
          end
          p++;
        end
        s++;
      end
    end
  end

endmodule

// File: rtl/issue_exe_stage.sv
// N-lane issue->EXE pipeline register with special-lane steering, group
// splitting on multiple specials, stall hold and deferred flush.
module issue_exe_stage
  import issue_exe_stage_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int PAYLOAD_W    = 256,
  parameter int SPECIAL_LANE = LANES - 1,
  parameter int SEQ_W        = $clog2(LANES)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES-1:0]             in_special,
  input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
  output logic                         in_ready,
  input  logic                         stall,
  input  logic                         flush,
  output logic [LANES-1:0]             ex_valid,
  output logic [LANES*PAYLOAD_W-1:0]   ex_payload,
  output logic [LANES*SEQ_W-1:0]       ex_seq,
  output logic                         ex_split
);

  localparam int CUT_W = cut_width(LANES);

  state_t                       state;
  logic                         flush_pend;
  logic [LANES-1:0]             hold_valid;
  logic [LANES-1:0]             hold_special;
  logic [LANES*PAYLOAD_W-1:0]   hold_payload;

  logic [LANES-1:0]             src_valid;
  logic [LANES-1:0]             src_special;
  logic [LANES*PAYLOAD_W-1:0]   src_payload;
  logic [CUT_W-1:0]             cut;
  logic [LANES-1:0]             lane_valid;
  logic [LANES*SEQ_W-1:0]       lane_src;
  logic [LANES*SEQ_W-1:0]       lane_seq;
  logic [LANES*PAYLOAD_W-1:0]   lane_payload;
  logic [LANES-1:0]             rem_mask;

  assign in_ready = (state == IDLE) & ~stall & ~flush & ~flush_pend;

  // While splitting, the hold buffer replaces the inputs as steering source.
  assign src_valid   = (state == SPLIT) ? hold_valid   : in_valid;
  assign src_special = (state == SPLIT) ? hold_special : in_special;
  assign src_payload = (state == SPLIT) ? hold_payload : in_payload;

  issue_lane_steer #(
    .LANES        (LANES),
    .SPECIAL_LANE (SPECIAL_LANE),
    .SEQ_W        (SEQ_W),
    .CUT_W        (CUT_W)
  ) u_steer (
    .valid      (src_valid),
    .special    (src_special),
    .cut        (cut),
    .lane_valid (lane_valid),
    .lane_src   (lane_src),
    .lane_seq   (lane_seq)
  );

  always_comb begin
    lane_payload = '0;
    rem_mask     = '0;
    for (int l = 0; l < LANES; l++) begin
      int idx;
      idx = int'(lane_src[l*SEQ_W +: SEQ_W]);
      if (lane_valid[l]) lane_payload[l*PAYLOAD_W +: PAYLOAD_W] = src_payload[idx*PAYLOAD_W +: PAYLOAD_W];
      rem_mask[l] = src_valid[l] & (l >= int'(cut));
    end
  end

  // EX output registers, FSM and hold buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      flush_pend   <= 1'b0;
      hold_valid   <= '0;
      hold_special <= '0;
      hold_payload <= '0;
      ex_valid     <= '0;
      ex_payload   <= '0;
      ex_seq       <= '0;
      ex_split     <= 1'b0;
    end else if (stall) begin
      // EX keeps its packet; a flush here only kills the pending remainder.
      if (flush) begin
        state        <= IDLE;
        flush_pend   <= 1'b1;
        hold_valid   <= '0;
        hold_special <= '0;
      end
    end else if (flush || flush_pend) begin
      state        <= IDLE;
      flush_pend   <= 1'b0;
      hold_valid   <= '0;
      hold_special <= '0;
      ex_valid     <= '0;
      ex_payload   <= '0;
      ex_seq       <= '0;
      ex_split     <= 1'b0;
    end else begin
      ex_valid   <= lane_valid;
      ex_payload <= lane_payload;
      ex_seq     <= lane_seq;
      ex_split   <= (state == SPLIT);
      if (|rem_mask) begin
        state        <= SPLIT;
        hold_valid   <= rem_mask;
        hold_special <= src_special & rem_mask;
        hold_payload <= src_payload;
      end else begin
        state        <= IDLE;
        hold_valid   <= '0;
        hold_special <= '0;
      end
    end
  end

endmodule
